// File: rtl/motor_relay_driver_if.sv
// -----------------------------------------------------------------------------
// motor_relay_driver_if
// Groups the command inputs and relay/status outputs of the window-motor relay
// driver so they travel as one bundle between the controller and the driver.
//
// Signals:
//   cmd_up      controller -> driver   request motor up (level, active-high)
//   cmd_down    controller -> driver   request motor down (level, active-high)
//   estop       controller -> driver   emergency stop / pinch (level, active-high)
//   Relay_UP_N  driver -> controller   up relay drive, active-low
//   Relay_DN_N  driver -> controller   down relay drive, active-low
//   busy        driver -> controller   high whenever the driver is not idle
//   state_o     driver -> controller   00 IDLE, 01 UP, 10 DOWN, 11 DEAD
//
// Modports:
//   master  the command source (drives commands, observes relays/status)
//   slave   the relay driver itself
// -----------------------------------------------------------------------------
interface motor_relay_driver_if;
    logic       cmd_up;
    logic       cmd_down;
    logic       estop;
    logic       Relay_UP_N;
    logic       Relay_DN_N;
    logic       busy;
    logic [1:0] state_o;

    modport master (
        output cmd_up, cmd_down, estop,
        input  Relay_UP_N, Relay_DN_N, busy, state_o
    );

    modport slave (
        input  cmd_up, cmd_down, estop,
        output Relay_UP_N, Relay_DN_N, busy, state_o
    );
endinterface

// File: rtl/motor_relay_driver.sv
// -----------------------------------------------------------------------------
// motor_relay_driver
// Drives the two active-low window-motor relays from debounced up/down commands
// and an emergency-stop request. Every change of drive passes through a DEAD
// phase with both relays off (break-before-make), and a normal release is held
// off until the relay has been energised for a minimum time. All outputs come
// straight from registers, so no input can reach a relay combinationally.
//
// Parameters:
//   T_DEAD   dead-time cycles with both relays off (>= 1)
//   T_MINON  minimum energised cycles before a normal release (>= 1)
//   CNT_W    timer width; T_DEAD and T_MINON must be < 2**CNT_W
//
// Ports:
//   SYSCLK   1 kHz system tick, rising edge
//   RST      asynchronous active-high reset (forces DEAD, both relays off)
//   bus      motor_relay_driver_if.slave: commands in, relays/status out
// -----------------------------------------------------------------------------
module motor_relay_driver #(
    parameter int T_DEAD  = 10,
    parameter int T_MINON = 20,
    parameter int CNT_W   = 16
) (
    input  logic                 SYSCLK,
    input  logic                 RST,
    motor_relay_driver_if.slave  bus
);

    // Encoding is chosen so the state register is directly the state_o code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_DEAD = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] C_MINON    = CNT_W'(T_MINON);
    localparam logic [CNT_W-1:0] C_DEAD_END = CNT_W'(T_DEAD - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_tmr;
    logic             r_up_n;
    logic             r_dn_n;
    logic             r_busy;

    // A direction is released when its own command drops or the opposite one
    // appears (a conflict counts as a release request).
    logic w_rel_up;
    logic w_rel_dn;
    logic w_start_up;
    logic w_start_dn;

    assign w_rel_up   = !bus.cmd_up   || bus.cmd_down;
    assign w_rel_dn   = !bus.cmd_down || bus.cmd_up;
    assign w_start_up = !bus.estop && bus.cmd_up   && !bus.cmd_down;
    assign w_start_dn = !bus.estop && bus.cmd_down && !bus.cmd_up;

    // Each transition updates the state and its decoded outputs together, so
    // the relay registers always agree with r_state.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; blocking would create order-dependent logic.
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_DEAD;
            r_tmr   <= '0;
            r_up_n  <= 1'b1;
            r_dn_n  <= 1'b1;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_up) begin
                        r_state <= ST_UP;
                        r_tmr   <= '0;
                        r_up_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (w_start_dn) begin
                        r_state <= ST_DOWN;
                        r_tmr   <= '0;
                        r_dn_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_UP: begin
                    // estop bypasses the minimum on-time.
                    if (bus.estop || (w_rel_up && r_tmr >= C_MINON)) begin
                        r_state <= ST_DEAD;
                        r_tmr   <= '0;
                        r_up_n  <= 1'b1;
                    end else if (r_tmr < C_MINON) begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                ST_DOWN: begin
                    if (bus.estop || (w_rel_dn && r_tmr >= C_MINON)) begin
                        r_state <= ST_DEAD;
                        r_tmr   <= '0;
                        r_dn_n  <= 1'b1;
                    end else if (r_tmr < C_MINON) begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                ST_DEAD: begin
                    // Inputs are deliberately ignored here; the next drive
                    // decision is always re-made from IDLE.
                    if (r_tmr == C_DEAD_END) begin
                        r_state <= ST_IDLE;
                        r_tmr   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_DEAD;
                    r_tmr   <= '0;
                    r_up_n  <= 1'b1;
                    r_dn_n  <= 1'b1;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.Relay_UP_N = r_up_n;
    assign bus.Relay_DN_N = r_dn_n;
    assign bus.busy       = r_busy;
    assign bus.state_o    = r_state;

endmodule

// File: tb/tb_motor_relay_driver.sv
// -----------------------------------------------------------------------------
// tb_motor_relay_driver
// Self-checking bench for motor_relay_driver. A behavioural model tracks which
// phase the driver should be in and when that phase began (absolute cycle
// number), and applies the timing rules as plain elapsed-time arithmetic.
// Outputs are sampled on the falling edge. Directed scenarios cover reset,
// normal run, short tap, reversal, estop and conflict; a randomized section
// follows.
// -----------------------------------------------------------------------------
module tb_motor_relay_driver;

    localparam int T_DEAD  = 10;
    localparam int T_MINON = 20;
    localparam int CNT_W   = 16;

    logic SYSCLK;
    logic RST;

    motor_relay_driver_if bus ();

    motor_relay_driver #(
        .T_DEAD  (T_DEAD),
        .T_MINON (T_MINON),
        .CNT_W   (CNT_W)
    ) dut (
        .SYSCLK (SYSCLK),
        .RST    (RST),
        .bus    (bus)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    typedef enum {PH_IDLE, PH_UP, PH_DOWN, PH_DEAD} phase_t;

    phase_t m_ph;
    int     m_cyc;   // modelled rising edges so far
    int     m_t0;    // cycle at which the current phase began

    function automatic logic [1:0] exp_code(input phase_t p);
        case (p)
            PH_IDLE: return 2'b00;
            PH_UP:   return 2'b01;
            PH_DOWN: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = PH_DEAD;
        m_t0 = m_cyc;
    endtask

    task automatic model_edge(input bit up, input bit dn, input bit es);
        int el;
        m_cyc++;
        el = m_cyc - m_t0;
        case (m_ph)
            PH_IDLE: begin
                if (!es && up && !dn) begin m_ph = PH_UP;   m_t0 = m_cyc; end
                else if (!es && dn && !up) begin m_ph = PH_DOWN; m_t0 = m_cyc; end
            end
            PH_UP: begin
                // Energised duration if released now is el cycles.
                if (es || ((!up || dn) && el >= T_MINON + 1)) begin
                    m_ph = PH_DEAD; m_t0 = m_cyc;
                end
            end
            PH_DOWN: begin
                if (es || ((!dn || up) && el >= T_MINON + 1)) begin
                    m_ph = PH_DEAD; m_t0 = m_cyc;
                end
            end
            default: begin
                if (el >= T_DEAD) begin m_ph = PH_IDLE; m_t0 = m_cyc; end
            end
        endcase
    endtask

    // ---------------------------------------------------------- run monitors
    int   s_cyc = 0;
    logic p_up_n = 1'b1, p_dn_n = 1'b1;
    int   up_start, up_end, dn_start, last_up_len, last_dn_len;

    task automatic sample_and_check();
        s_cyc++;
        check("state_o", bus.state_o, exp_code(m_ph));
        check("relay_up_n", bus.Relay_UP_N, (m_ph == PH_UP) ? 1'b0 : 1'b1);
        check("relay_dn_n", bus.Relay_DN_N, (m_ph == PH_DOWN) ? 1'b0 : 1'b1);
        check("busy", bus.busy, (m_ph != PH_IDLE) ? 1'b1 : 1'b0);
        check("no_overlap", bus.Relay_UP_N | bus.Relay_DN_N, 1'b1);
        if (p_up_n && !bus.Relay_UP_N) up_start = s_cyc;
        if (!p_up_n && bus.Relay_UP_N) begin last_up_len = s_cyc - up_start; up_end = s_cyc; end
        if (p_dn_n && !bus.Relay_DN_N) dn_start = s_cyc;
        if (!p_dn_n && bus.Relay_DN_N) last_dn_len = s_cyc - dn_start;
        p_up_n = bus.Relay_UP_N;
        p_dn_n = bus.Relay_DN_N;
    endtask

    // Apply inputs at the falling edge, hold for n cycles, check each cycle.
    task automatic run(input bit up, input bit dn, input bit es, input int n);
        for (int i = 0; i < n; i++) begin
            bus.cmd_up   = up;
            bus.cmd_down = dn;
            bus.estop    = es;
            @(posedge SYSCLK);
            model_edge(up, dn, es);
            @(negedge SYSCLK);
            sample_and_check();
        end
    endtask

    // Asynchronous reset asserted between edges; relays must drop at once.
    task automatic async_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check("rst_up_n", bus.Relay_UP_N, 1'b1);
        check("rst_dn_n", bus.Relay_DN_N, 1'b1);
        check("rst_busy", bus.busy, 1'b1);
        check("rst_state", bus.state_o, 2'b11);
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        RST = 1'b0;
        p_up_n = bus.Relay_UP_N;
        p_dn_n = bus.Relay_DN_N;
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        bus.cmd_up   = 1'b0;
        bus.cmd_down = 1'b0;
        bus.estop    = 1'b0;
        RST          = 1'b1;
        m_cyc        = 0;
        model_reset();
        #1;
        check("reset_state", bus.state_o, 2'b11);
        check("reset_relays", {bus.Relay_UP_N, bus.Relay_DN_N}, 2'b11);
        check("reset_busy", bus.busy, 1'b1);
        repeat (2) @(negedge SYSCLK);
        RST = 1'b0;

        // Full dead time after reset, then idle.
        run(0, 0, 0, T_DEAD + 3);
        check("idle_after_reset", bus.busy, 1'b0);

        // Reset in the middle of an up run.
        run(1, 0, 0, 15);
        async_reset();
        run(0, 0, 0, T_DEAD - 1);
        check("still_dead", bus.state_o, 2'b11);
        run(0, 0, 0, 2);
        check("idle_after_midrun_reset", bus.busy, 1'b0);

        // Normal up run of 50 cycles.
        run(1, 0, 0, 50);
        run(0, 0, 0, T_DEAD + 3);
        check("up_run_len", last_up_len, 50);

        // Single-cycle down tap stretched to T_MINON+1.
        run(0, 1, 0, 1);
        run(0, 0, 0, T_MINON + T_DEAD + 5);
        check("tap_len", last_dn_len, T_MINON + 1);

        // Reversal: up held 40, then down.
        run(1, 0, 0, 40);
        run(0, 1, 0, 15);
        check("reversal_gap", dn_start - up_end, T_DEAD + 1);
        run(0, 0, 0, T_MINON + T_DEAD + 5);

        // estop at cycle 3 of UP, then held with cmd_up still requested.
        run(1, 0, 0, 3);
        run(1, 0, 1, 1);
        check("estop_release", bus.Relay_UP_N, 1'b1);
        run(1, 0, 1, T_DEAD + 5);
        check("estop_hold_idle", bus.state_o, 2'b00);
        run(0, 0, 0, 2);

        // Conflict in IDLE, then conflict as release while in UP.
        run(1, 1, 0, 5);
        check("conflict_idle", bus.state_o, 2'b00);
        run(1, 0, 0, T_MINON + 5);
        run(1, 1, 0, 1);
        check("conflict_release", bus.state_o, 2'b11);
        run(0, 0, 0, T_DEAD + 2);

        // Randomized segments with occasional mid-run resets.
        for (int seg = 0; seg < 200; seg++) begin
            bit up, dn, es;
            up = 1'($urandom_range(0, 1));
            dn = 1'($urandom_range(0, 1));
            es = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) async_reset();
            run(up, dn, es, $urandom_range(1, 30));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_relay_driver.md
# motor_relay_driver

Output-side relay driver for the window motor in the anti-pinch controller. It takes clean, already-debounced up/down commands and an emergency-stop request. It drives the two active-low motor relays with guaranteed break-before-make dead time and a minimum on-time, so the relays can never be energised together or chattered. It runs on the same 1 kHz system tick as the key-input path, so all time constants below are in milliseconds.

## Interface
Parameters:
- `T_DEAD`, 10: dead-time cycles, both relays off, between any two drive states (≥1).
- `T_MINON`, 20: minimum cycles a relay stays energised before a normal release takes effect (≥1).
- `CNT_W`, 16: width of the internal timer; `T_DEAD` and `T_MINON` must be < 2^`CNT_W`.

Ports:
- `SYSCLK`, in, 1: system clock, 1 kHz, rising-edge.
- `RST`, in, 1: reset, asynchronous, active-high.
- `cmd_up`, in, 1: request motor up, level, active-high.
- `cmd_down`, in, 1: request motor down, level, active-high.
- `estop`, in, 1: emergency stop (pinch detected), level, active-high.
- `Relay_UP_N`, out, 1: up relay drive, active-low.
- `Relay_DN_N`, out, 1: down relay drive, active-low.
- `busy`, out, 1: high when not in IDLE.
- `state_o`, out, 2: encoded state: 00 IDLE, 01 UP, 10 DOWN, 11 DEAD.

## Operation
- Single FSM with states IDLE, UP, DOWN and DEAD, plus one `CNT_W`-bit timer `tmr`.
- All outputs decode from the state register only; there is no combinational path from inputs to outputs.
- Relay drive:
  - `Relay_UP_N` = 0 only in UP.
  - `Relay_DN_N` = 0 only in DOWN.
  - Both relays are 1 in every other state.
  - Both relays low at the same time is illegal and must never occur.
- IDLE:
  - `estop` = 1 → stay in IDLE.
  - Else `cmd_up` & !`cmd_down` → UP.
  - Else `cmd_down` & !`cmd_up` → DOWN.
  - Both commands high (conflict) or neither high → stay in IDLE.
  - On entry to UP or DOWN, `tmr` ← 0.
- UP:
  - `tmr` increments each cycle and saturates at `T_MINON`.
  - `estop` = 1 → DEAD immediately, ignoring `T_MINON`.
  - Release condition is (!`cmd_up` | `cmd_down`). If it holds and `tmr` ≥ `T_MINON` → DEAD.
  - Otherwise stay in UP.
- DOWN: same as UP, with `cmd_down` and `cmd_up` swapped.
- DEAD:
  - `tmr` ← 0 on entry, then increments each cycle.
  - When `tmr` = `T_DEAD`-1 → IDLE.
  - Inputs are ignored in DEAD, including `estop`.
- Direction reversal always passes through DEAD and then IDLE, so the opposite relay is re-evaluated in IDLE.
- Reset:
  - Asserting `RST` forces state DEAD and `tmr` = 0 asynchronously.
  - This de-energises both relays immediately, including mid-run.
  - After release, DEAD runs its full `T_DEAD` cycles before IDLE.

## Timing
- Reset values: `Relay_UP_N`=1, `Relay_DN_N`=1, `busy`=1, `state_o`=11.
- Start latency: a command sampled at rising edge k in IDLE gives a relay low from edge k onward (1 cycle after the input is set up).
- Minimum energised time: `T_MINON`+1 cycles for a normal release.
- `estop` latency: relay released at the first rising edge that samples `estop` = 1.
- Dead time: exactly `T_DEAD` cycles with both relays off, followed by at least 1 IDLE cycle.
  - Minimum gap between one relay releasing and the other energising is `T_DEAD`+1 cycles.
- Timer never wraps: saturation in UP/DOWN, bounded count in DEAD.
- `estop` and release in the same cycle: result is DEAD, identical to `estop` alone.

## Test plan
- Reset then idle: assert `RST` mid-UP → both relays 1 at once, `state_o`=11; after release, 10 cycles in DEAD, then IDLE with `busy`=0.
- Normal up run: `cmd_up`=1 for 50 cycles → `Relay_UP_N` low for 50 cycles, then 10 DEAD cycles, then IDLE.
- Short tap: `cmd_down` pulse of 1 cycle → `Relay_DN_N` low for exactly 21 cycles, then 10 DEAD cycles.
- Reversal: `cmd_up` held 40 cycles, then switch to `cmd_down` → UP releases, 10 DEAD cycles, 1 IDLE cycle, then DOWN. Relays never both 0 (checked by assertion).
- `estop` at cycle 3 of UP → relay released next edge despite `T_MINON`. With `estop` held, remains IDLE after DEAD even though `cmd_up`=1.
- Conflict: `cmd_up`=`cmd_down`=1 in IDLE → stays IDLE with relays 1. In UP past `T_MINON`, raising `cmd_down` → DEAD.
